// File: rtl/cache_data_array_nway.sv
// cache_data_array_nway: N-way set-associative cache data array.
// Registered 1-cycle reads from every way, one-hot per-way single-word
// writes, and a line-fill sequencer that streams WORDS words into one way.
// Optional macro CACHE_DATA_ARRAY_NWAY_RD_BYPASS_EN: a same-cycle read of a
// word being written returns the new data in the written way(s); without
// it reads are read-first (old data).
module cache_data_array_nway #(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int WORDS = 8,
  parameter int DW    = 16,
  parameter int SW    = $clog2(SETS),
  parameter int OW    = $clog2(WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic [SW-1:0]      rd_set,
  input  logic [OW-1:0]      rd_word,
  output logic [WAYS*DW-1:0] rd_data,
  output logic               rd_valid,
  input  logic               wr_en,
  input  logic [WAYS-1:0]    wr_way,
  input  logic [SW-1:0]      wr_set,
  input  logic [OW-1:0]      wr_word,
  input  logic [DW-1:0]      wr_data,
  input  logic               fill_start,
  input  logic [SW-1:0]      fill_set,
  input  logic [WAYS-1:0]    fill_way,
  input  logic [DW-1:0]      fill_data,
  input  logic               fill_valid,
  output logic               fill_busy,
  output logic               fill_done
);

  localparam int AW    = SW + OW;
  localparam int DEPTH = SETS * WORDS;
  localparam logic [OW-1:0] LAST_WORD = OW'(WORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [OW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     fset_q, fset_d;
  logic [WAYS-1:0]   fway_q, fway_d;

  logic [DW-1:0]     mem_q [WAYS][DEPTH];
  logic [WAYS-1:0]   mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [AW-1:0]     rd_addr;

  logic [WAYS*DW-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q;

  assign rd_addr   = {rd_set, rd_word};
  assign fill_busy = (state_q == ST_FILL);
  assign fill_done = (state_q == ST_DONE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

  // Select the single storage write port: the fill owns it while busy, and
  // host writes issued during a fill are dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_FILL) begin
      if (fill_valid) begin
        mem_we    = fway_q;
        mem_addr  = {fset_q, cnt_q};
        mem_wdata = fill_data;
      end
    end else if (wr_en) begin
      mem_we    = wr_way;
      mem_addr  = {wr_set, wr_word};
      mem_wdata = wr_data;
    end
  end

  // Fill sequencer next-state: latch target on start, count words, pulse done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fset_d  = fset_q;
    fway_d  = fway_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          fset_d  = fill_set;
          fway_d  = fill_way;
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (fill_valid) begin
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Fill sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fset_q  <= '0;
      fway_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fset_q  <= fset_d;
      fway_q  <= fway_d;
    end
  end

  // Storage array: one write port shared by host writes and the fill.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the array must read back as zero immediately after reset, so it
    // is built from resettable flops rather than an inferred RAM macro.
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[w][i] <= '0;
        end
      end
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (mem_we[w]) begin
          mem_q[w][mem_addr] <= mem_wdata;
        end
      end
    end
  end

  // Gather the addressed word from every way, optionally forwarding a
  // same-cycle write into the way(s) it targets.
  always_comb begin
    rd_data_d = '0;
    for (int w = 0; w < WAYS; w++) begin
      rd_data_d[w*DW +: DW] = mem_q[w][rd_addr];
`ifdef CACHE_DATA_ARRAY_NWAY_RD_BYPASS_EN
      if (mem_we[w] && (mem_addr == rd_addr)) begin
        rd_data_d[w*DW +: DW] = mem_wdata;
      end
`endif
    end
  end

  // Registered read port: data holds between reads, valid is a 1-cycle echo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

endmodule

// File: tb/tb_cache_data_array_nway.sv
// Self-checking bench for cache_data_array_nway (WAYS=2, SETS=64, WORDS=8,
// DW=16). Table-driven single-cycle read/write vectors, then hand-written
// fill, conflict and reset sequences.
module tb_cache_data_array_nway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [5:0]  rd_set = '0;
  logic [2:0]  rd_word = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_way = '0;
  logic [5:0]  wr_set = '0;
  logic [2:0]  wr_word = '0;
  logic [15:0] wr_data = '0;
  logic        fill_start = 1'b0;
  logic [5:0]  fill_set = '0;
  logic [1:0]  fill_way = '0;
  logic [15:0] fill_data = '0;
  logic        fill_valid = 1'b0;
  logic        fill_busy;
  logic        fill_done;

  int checks = 0;
  int errors = 0;

  cache_data_array_nway #(.WAYS(2), .SETS(64), .WORDS(8), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_set(rd_set), .rd_word(rd_word),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_way(wr_way), .wr_set(wr_set), .wr_word(wr_word),
    .wr_data(wr_data),
    .fill_start(fill_start), .fill_set(fill_set), .fill_way(fill_way),
    .fill_data(fill_data), .fill_valid(fill_valid),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [1:0]  wr_way;
    logic [5:0]  wr_set;
    logic [2:0]  wr_word;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [5:0]  rd_set;
    logic [2:0]  rd_word;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rd_en = 1'b0; wr_en = 1'b0; fill_start = 1'b0; fill_valid = 1'b0;
  endtask

  task automatic read_word(input logic [5:0] s, input logic [2:0] w,
                           input logic [31:0] exp, input string name);
    quiet();
    rd_en = 1'b1; rd_set = s; rd_word = w;
    tick();
    rd_en = 1'b0;
    check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({name, "_data"}, rd_data, exp);
  endtask

  initial begin
    // vector: wr_en way set word data | rd_en set word | exp_valid exp_data
    vecs[0]  = '{1'b1, 2'b10, 6'd7,  3'd2, 16'hBEEF, 1'b0, 6'd0,  3'd0, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 2'b00, 6'd0,  3'd0, 16'h0000, 1'b1, 6'd7,  3'd2, 1'b1, 32'hBEEF_0000};
    vecs[2]  = '{1'b0, 2'b00, 6'd0,  3'd0, 16'h0000, 1'b0, 6'd0,  3'd0, 1'b0, 32'hBEEF_0000};
    vecs[3]  = '{1'b1, 2'b01, 6'd7,  3'd2, 16'hCAFE, 1'b0, 6'd0,  3'd0, 1'b0, 32'hBEEF_0000};
    vecs[4]  = '{1'b0, 2'b00, 6'd0,  3'd0, 16'h0000, 1'b1, 6'd7,  3'd2, 1'b1, 32'hBEEF_CAFE};
    vecs[5]  = '{1'b1, 2'b11, 6'd3,  3'd0, 16'h1111, 1'b0, 6'd0,  3'd0, 1'b0, 32'hBEEF_CAFE};
`ifdef CACHE_DATA_ARRAY_NWAY_RD_BYPASS_EN
    vecs[6]  = '{1'b1, 2'b11, 6'd3,  3'd0, 16'h2222, 1'b1, 6'd3,  3'd0, 1'b1, 32'h2222_2222};
`else
    vecs[6]  = '{1'b1, 2'b11, 6'd3,  3'd0, 16'h2222, 1'b1, 6'd3,  3'd0, 1'b1, 32'h1111_1111};
`endif
    vecs[7]  = '{1'b0, 2'b00, 6'd0,  3'd0, 16'h0000, 1'b1, 6'd3,  3'd0, 1'b1, 32'h2222_2222};
    vecs[8]  = '{1'b1, 2'b00, 6'd3,  3'd0, 16'h3333, 1'b0, 6'd0,  3'd0, 1'b0, 32'h2222_2222};
    vecs[9]  = '{1'b0, 2'b00, 6'd0,  3'd0, 16'h0000, 1'b1, 6'd3,  3'd0, 1'b1, 32'h2222_2222};
`ifdef CACHE_DATA_ARRAY_NWAY_RD_BYPASS_EN
    vecs[10] = '{1'b1, 2'b01, 6'd3,  3'd0, 16'h4444, 1'b1, 6'd3,  3'd0, 1'b1, 32'h2222_4444};
`else
    vecs[10] = '{1'b1, 2'b01, 6'd3,  3'd0, 16'h4444, 1'b1, 6'd3,  3'd0, 1'b1, 32'h2222_2222};
`endif
    vecs[11] = '{1'b0, 2'b00, 6'd0,  3'd0, 16'h0000, 1'b1, 6'd3,  3'd0, 1'b1, 32'h2222_4444};
    vecs[12] = '{1'b0, 2'b00, 6'd0,  3'd0, 16'h0000, 1'b1, 6'd3,  3'd1, 1'b1, 32'h0000_0000};
    vecs[13] = '{1'b1, 2'b10, 6'd63, 3'd7, 16'hABCD, 1'b0, 6'd0,  3'd0, 1'b0, 32'h0000_0000};
    vecs[14] = '{1'b0, 2'b00, 6'd0,  3'd0, 16'h0000, 1'b1, 6'd63, 3'd7, 1'b1, 32'hABCD_0000};

    // ---- reset state ----
    #3;
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_fill_busy", {31'd0, fill_busy}, 32'd0);
    check("reset_fill_done", {31'd0, fill_done}, 32'd0);
    tick();
    rst = 1'b0;

    // ---- table-driven read/write vectors ----
    for (int i = 0; i < NVEC; i++) begin
      wr_en = vecs[i].wr_en;  wr_way = vecs[i].wr_way;
      wr_set = vecs[i].wr_set; wr_word = vecs[i].wr_word;
      wr_data = vecs[i].wr_data;
      rd_en = vecs[i].rd_en;  rd_set = vecs[i].rd_set;
      rd_word = vecs[i].rd_word;
      tick();
      check($sformatf("vec%0d_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
    end
    quiet();
    tick();

    // ---- fill with gaps, conflicting requests, reads during fill ----
    fill_start = 1'b1; fill_set = 6'd63; fill_way = 2'b01;
    tick();
    fill_start = 1'b0;
    check("fill_busy_start", {31'd0, fill_busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        // Two idle cycles; the first carries a stray fill_start and a host
        // write, both of which must be ignored.
        fill_valid = 1'b0;
        fill_start = 1'b1; fill_set = 6'd5; fill_way = 2'b10;
        wr_en = 1'b1; wr_way = 2'b10; wr_set = 6'd7; wr_word = 3'd2;
        wr_data = 16'hDEAD;
        tick();
        fill_start = 1'b0; wr_en = 1'b0;
        check("fill_gap0_busy", {31'd0, fill_busy}, 32'd1);
        tick();
        check("fill_gap1_busy", {31'd0, fill_busy}, 32'd1);
        check("fill_gap1_done", {31'd0, fill_done}, 32'd0);
      end
      fill_valid = 1'b1; fill_data = 16'h1000 + 16'(i);
      rd_en = (i == 1) || (i == 2);
      rd_set = 6'd63; rd_word = (i == 1) ? 3'd0 : 3'd5;
      tick();
      rd_en = 1'b0;
      if (i == 1) check("fill_rd_filled_word", rd_data, 32'h0000_1000);
      if (i == 2) check("fill_rd_unfilled_word", rd_data, 32'h0000_0000);
      if (i < 7) begin
        check($sformatf("fill_w%0d_busy", i), {31'd0, fill_busy}, 32'd1);
        check($sformatf("fill_w%0d_done", i), {31'd0, fill_done}, 32'd0);
      end else begin
        check("fill_last_busy", {31'd0, fill_busy}, 32'd0);
        check("fill_last_done", {31'd0, fill_done}, 32'd1);
      end
    end
    // In DONE: fill_start and fill_valid must both be ignored.
    fill_start = 1'b1; fill_set = 6'd5; fill_way = 2'b10;
    fill_valid = 1'b1; fill_data = 16'h9999;
    tick();
    quiet();
    check("after_done_busy", {31'd0, fill_busy}, 32'd0);
    check("after_done_done", {31'd0, fill_done}, 32'd0);
    tick();
    check("idle_busy", {31'd0, fill_busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      read_word(6'd63, 3'(i), {(i == 7) ? 16'hABCD : 16'h0000, 16'h1000 + 16'(i)},
                $sformatf("fill_rd%0d", i));
    end
    read_word(6'd7, 3'd2, 32'hBEEF_CAFE, "wr_during_fill_dropped");
    read_word(6'd5, 3'd0, 32'h0000_0000, "stray_fill_start_ignored");

    // ---- asynchronous reset in the middle of a fill ----
    fill_start = 1'b1; fill_set = 6'd5; fill_way = 2'b10;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fill_valid = 1'b1; fill_data = 16'h2000 + 16'(i);
      tick();
    end
    fill_valid = 1'b0;
    check("midfill_busy_before_rst", {31'd0, fill_busy}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_busy", {31'd0, fill_busy}, 32'd0);
    check("rst_async_done", {31'd0, fill_done}, 32'd0);
    check("rst_async_rd_data", rd_data, 32'd0);
    check("rst_async_rd_valid", {31'd0, rd_valid}, 32'd0);
    rd_en = 1'b1; rd_set = 6'd5; rd_word = 3'd3;
    tick();
    check("rst_held_rd_valid", {31'd0, rd_valid}, 32'd0);
    rst = 1'b0;
    tick();
    rd_en = 1'b0;
    check("post_rst_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("post_rst_set5_word3", rd_data, 32'd0);
    check("post_rst_no_done", {31'd0, fill_done}, 32'd0);
    tick();
    check("post_rst_no_done2", {31'd0, fill_done}, 32'd0);
    check("post_rst_idle", {31'd0, fill_busy}, 32'd0);
    read_word(6'd7, 3'd2, 32'h0000_0000, "post_rst_cleared");

    // ---- a fresh fill completes normally after the abandoned one ----
    fill_start = 1'b1; fill_set = 6'd5; fill_way = 2'b10;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fill_valid = 1'b1; fill_data = 16'h3000 + 16'(i);
      tick();
    end
    fill_valid = 1'b0;
    check("refill_done", {31'd0, fill_done}, 32'd1);
    check("refill_busy", {31'd0, fill_busy}, 32'd0);
    tick();
    check("refill_done_cleared", {31'd0, fill_done}, 32'd0);
    read_word(6'd5, 3'd3, 32'h3003_0000, "refill_word3");
    read_word(6'd5, 3'd7, 32'h3007_0000, "refill_word7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
